clk_period_meter: RTL and testbench



---
 rtl/clk_meter_pkg.sv | 18 +
 rtl/sync_edge_det.sv | 30 +++
 rtl/clk_period_meter.sv | 118 +++++++++++
 tb/tb_clk_period_meter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared types and constants for the clock period meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Smallest counter width able to hold values up to timeout.
  function automatic int min_cnt_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer for an asynchronous level plus rising/falling edge detection.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in clk cycles,
// with a sticky loss-of-clock flag.
//
// state   | meaning
// IDLE    | disabled, counters cleared
// ARM     | waiting for the first rising edge (no reference yet)
// MEASURE | counting from the last rising edge; each new edge reports
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             no_clk
);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $error("clk_period_meter: SYNC_STAGES out of range");
    end
    if (TIMEOUT < 4 || min_cnt_w(TIMEOUT) > CNT_W) begin : g_bad_timeout
      $error("clk_period_meter: TIMEOUT does not fit CNT_W or is below 4");
    end
  endgenerate

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic s;
  logic rise;
  logic fall_unused;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (clk_in),
    .s    (s),
    .rise (rise),
    .fall (fall_unused)
  );

  meter_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_cnt     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      no_clk     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!meas_en) begin
        state  <= IDLE;
        cnt    <= '0;
        hi_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state  <= ARM;
            cnt    <= '0;
            hi_cnt <= '0;
          end
          ARM: begin
            if (rise) begin
              state  <= MEASURE;
              cnt    <= CNT_W'(1);
              hi_cnt <= CNT_W'(1);
            end else if (cnt == TO_LAST) begin
              no_clk <= 1'b1;
              cnt    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          MEASURE: begin
            // A rise coinciding with the timeout compare is a valid period.
            if (rise) begin
              period     <= cnt;
              high_time  <= hi_cnt;
              meas_valid <= 1'b1;
              no_clk     <= 1'b0;
              cnt        <= CNT_W'(1);
              hi_cnt     <= CNT_W'(1);
            end else if (cnt == TO_LAST) begin
              state  <= ARM;
              no_clk <= 1'b1;
              cnt    <= '0;
              hi_cnt <= '0;
            end else begin
              cnt    <= cnt + 1'b1;
              hi_cnt <= hi_cnt + CNT_W'(s);
            end
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            hi_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: timestamp-based reference model plus directed checks.
module tb_clk_period_meter;

  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 100;
  localparam int MAXE        = 60000;

  logic             clk = 1'b0;
  logic             rst;
  logic             clk_in;
  logic             meas_en;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             no_clk;

  int checks   = 0;
  int failures = 0;

  clk_period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_in     (clk_in),
    .meas_en    (meas_en),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .no_clk     (no_clk)
  );

  always #5 clk = ~clk;

  // Reference model: edge timestamps, sampled input history and plain sums.
  bit in_hist [MAXE];
  int e = 0;
  int last_rst = -10;
  bit m_armed, m_have_ref, m_valid, m_noclk;
  int m_ref, m_arm_start, m_period, m_high;

  // Waveform generator and observation bookkeeping.
  int wave_mode, wave_p, wave_h, ph;
  bit wave_lvl;
  int vcount, last_valid_edge, noclk_rise_edge;
  bit prev_noclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic bit s_at(input int k);
    if (k - SYNC_STAGES < 0 || k - SYNC_STAGES <= last_rst) return 1'b0;
    return in_hist[k - SYNC_STAGES];
  endfunction

  task automatic model_step();
    bit r;
    int sum;
    e++;
    in_hist[e] = clk_in;
    m_valid = 1'b0;
    if (rst) begin
      last_rst = e; m_armed = 0; m_have_ref = 0;
      m_period = 0; m_high = 0; m_noclk = 0;
    end else if (!meas_en) begin
      m_armed = 0; m_have_ref = 0;
    end else if (!m_armed) begin
      m_armed = 1; m_have_ref = 0; m_arm_start = e + 1;
    end else begin
      r = s_at(e) && !s_at(e - 1);
      if (r) begin
        if (m_have_ref) begin
          sum = 0;
          for (int k = m_ref; k < e; k++) sum += int'(s_at(k));
          m_period = e - m_ref; m_high = sum; m_valid = 1; m_noclk = 0;
        end
        m_have_ref = 1; m_ref = e;
      end else if (m_have_ref && (e - m_ref == TIMEOUT - 1)) begin
        m_noclk = 1; m_have_ref = 0; m_arm_start = e + 1;
      end else if (!m_have_ref && (e - m_arm_start == TIMEOUT - 1)) begin
        m_noclk = 1; m_arm_start = e + 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (wave_mode == 0) begin
      clk_in = (ph < wave_h);
      ph = (ph + 1 >= wave_p) ? 0 : ph + 1;
    end else begin
      clk_in = wave_lvl;
    end
    @(posedge clk);
    model_step();
    #1;
    if (meas_valid === 1'b1) begin vcount++; last_valid_edge = e; end
    if (no_clk === 1'b1 && !prev_noclk) noclk_rise_edge = e;
    prev_noclk = (no_clk === 1'b1);
    chk("m_period", 32'(period), 32'(m_period));
    chk("m_high_time", 32'(high_time), 32'(m_high));
    chk("m_meas_valid", 32'(meas_valid), 32'(m_valid));
    chk("m_no_clk", 32'(no_clk), 32'(m_noclk));
  endtask

  task automatic set_wave(input int p, input int h);
    wave_mode = 0; wave_p = p; wave_h = h; ph = 0;
  endtask

  task automatic set_level(input bit l);
    wave_mode = 1; wave_lvl = l;
  endtask

  task automatic chk_result(input string tag, input int p, input int h, input bit nc);
    chk({tag, "_period"}, 32'(period), 32'(p));
    chk({tag, "_high"}, 32'(high_time), 32'(h));
    chk({tag, "_no_clk"}, 32'(no_clk), 32'(nc));
  endtask

  initial begin
    rst = 1'b1; meas_en = 1'b0; clk_in = 1'b0;
    set_level(1'b0);
    vcount = 0; last_valid_edge = -1; noclk_rise_edge = -1; prev_noclk = 0;

    repeat (3) tick();
    chk_result("reset", 0, 0, 1'b0);
    chk("reset_valid", 32'(meas_valid), 0);

    // Even ratio 6/3
    rst = 1'b0; meas_en = 1'b1; set_wave(6, 3);
    repeat (40) tick();
    vcount = 0;
    repeat (30) tick();
    chk("even_pulses", 32'(vcount), 5);
    chk_result("even", 6, 3, 1'b0);

    // Odd ratio 5/2 then 5/3
    set_wave(5, 2);
    repeat (40) tick();
    chk_result("odd52", 5, 2, 1'b0);
    set_wave(5, 3);
    repeat (20) tick();
    chk_result("odd53", 5, 3, 1'b0);

    // Timeout after a 6/3 run, then recovery
    set_wave(6, 3);
    repeat (40) tick();
    set_level(1'b0);
    vcount = 0; noclk_rise_edge = -1;
    repeat (150) tick();
    chk("to_pulses", 32'(vcount), 0);
    chk_result("to_hold", 6, 3, 1'b1);
    // last valid marks the edge the last rise was taken; no_clk follows TIMEOUT-1 edges later
    chk("to_latency", 32'(noclk_rise_edge - last_valid_edge), 32'(TIMEOUT - 1));
    set_wave(6, 3);
    repeat (20) tick();
    chk_result("to_recover", 6, 3, 1'b0);

    // Enable drop mid-period
    repeat (15) tick();
    meas_en = 1'b0; vcount = 0;
    repeat (12) tick();
    chk("en_pulses", 32'(vcount), 0);
    chk_result("en_hold", 6, 3, 1'b0);
    meas_en = 1'b1;
    repeat (25) tick();
    chk_result("en_resume", 6, 3, 1'b0);

    // Mid-measurement reset
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk_result("midrst", 0, 0, 1'b0);
    chk("midrst_valid", 32'(meas_valid), 0);
    rst = 1'b0;
    repeat (30) tick();
    chk_result("midrst_resume", 6, 3, 1'b0);

    // Minimum legal input 4/2
    set_wave(4, 2);
    repeat (30) tick();
    vcount = 0;
    repeat (20) tick();
    chk("min_pulses", 32'(vcount), 5);
    chk_result("min", 4, 2, 1'b0);

    // Constant high: timeout only
    set_level(1'b1);
    repeat (10) tick();
    vcount = 0;
    repeat (250) tick();
    chk("hi_pulses", 32'(vcount), 0);
    chk("hi_no_clk", 32'(no_clk), 1);

    // Rise coinciding with the timeout compare wins; one cycle longer times out
    set_wave(TIMEOUT - 1, 50);
    repeat (3 * TIMEOUT) tick();
    chk_result("tie", TIMEOUT - 1, 50, 1'b0);
    set_wave(TIMEOUT, 50);
    vcount = 0;
    repeat (3 * TIMEOUT) tick();
    chk("over_pulses", 32'(vcount), 0);
    chk("over_no_clk", 32'(no_clk), 1);

    // Randomized segments
    for (int i = 0; i < 24; i++) begin
      int p, h, n;
      p = int'($urandom_range(4, (i % 4 == 3) ? 120 : 30));
      h = int'($urandom_range(2, p - 2));
      n = int'($urandom_range(3 * p + 2, 6 * p));
      set_wave(p, h);
      ph = int'($urandom_range(0, p - 1));
      repeat (n) tick();
      if (p < TIMEOUT) chk_result("rand", p, h, 1'b0);
      else chk("rand_no_clk", 32'(no_clk), 1);
      if ($urandom_range(0, 3) == 0) begin
        meas_en = 1'b0;
        repeat (int'($urandom_range(1, 8))) tick();
        meas_en = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
